// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the two common data buses between NUM_REQ result
// producers. Outputs are registered; each bus idles for one cycle after a broadcast.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      resetAll,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*TAG_W-1:0]  reqRob,
  input  logic [NUM_REQ*DATA_W-1:0] reqData,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      CDBisCast1,
  output logic [TAG_W-1:0]          CDBrobNum1,
  output logic [DATA_W-1:0]         CDBdata1,
  output logic                      CDBisCast2,
  output logic [TAG_W-1:0]          CDBrobNum2,
  output logic [DATA_W-1:0]         CDBdata2,
  output logic [7:0]                dropCount
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W = PTR_W + 1;
  localparam logic [TAG_W-1:0] NO_ROB = TAG_W'(16);

  // (base + k) mod NUM_REQ for k < NUM_REQ
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                 input int unsigned     k);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, base} + SUM_W'(k);
    if (sum >= SUM_W'(NUM_REQ)) begin
      sum = sum - SUM_W'(NUM_REQ);
    end
    return sum[PTR_W-1:0];
  endfunction

  logic [TAG_W-1:0]   rob_arr  [NUM_REQ];
  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_d;
  logic [PTR_W-1:0]   idx;
  logic [NUM_REQ-1:0] grant_d;
  logic               cast1_d;
  logic               cast2_d;
  logic [TAG_W-1:0]   rob1_d;
  logic [TAG_W-1:0]   rob2_d;
  logic [DATA_W-1:0]  data1_d;
  logic [DATA_W-1:0]  data2_d;
  logic [1:0]         drops;
  logic               first_taken;
  logic               second_taken;
  logic [8:0]         drop_sum;
  logic [7:0]         drop_d;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rob_arr[i]  = reqRob[i*TAG_W +: TAG_W];
      data_arr[i] = reqData[i*DATA_W +: DATA_W];
    end
  end

  // A result granted this cycle is consumed at the coming edge, so mask it.
  assign elig = req & ~grant;

  // Rotating scan: first eligible takes a free bus (CDB1 first); a second
  // eligible takes CDB2 only when both buses are free.
  always_comb begin
    grant_d      = '0;
    cast1_d      = 1'b0;
    cast2_d      = 1'b0;
    rob1_d       = CDBrobNum1;
    rob2_d       = CDBrobNum2;
    data1_d      = CDBdata1;
    data2_d      = CDBdata2;
    ptr_d        = ptr;
    drops        = 2'd0;
    first_taken  = 1'b0;
    second_taken = 1'b0;
    idx          = '0;
    if (!resetAll) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = wrap_idx(ptr, k);
        if (elig[idx] && !second_taken) begin
          if (!first_taken && (!CDBisCast1 || !CDBisCast2)) begin
            first_taken  = 1'b1;
            grant_d[idx] = 1'b1;
            ptr_d        = wrap_idx(idx, 32'd1);
            if (rob_arr[idx] >= NO_ROB) begin
              drops = drops + 2'd1;
            end else if (!CDBisCast1) begin
              cast1_d = 1'b1;
              rob1_d  = rob_arr[idx];
              data1_d = data_arr[idx];
            end else begin
              cast2_d = 1'b1;
              rob2_d  = rob_arr[idx];
              data2_d = data_arr[idx];
            end
          end else if (first_taken && !CDBisCast1 && !CDBisCast2) begin
            second_taken = 1'b1;
            grant_d[idx] = 1'b1;
            ptr_d        = wrap_idx(idx, 32'd1);
            if (rob_arr[idx] >= NO_ROB) begin
              drops = drops + 2'd1;
            end else begin
              cast2_d = 1'b1;
              rob2_d  = rob_arr[idx];
              data2_d = data_arr[idx];
            end
          end
        end
      end
    end
  end

  // Saturating drop counter.
  always_comb begin
    drop_sum = {1'b0, dropCount} + 9'(drops);
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= '0;
      CDBisCast1 <= 1'b0;
      CDBrobNum1 <= NO_ROB;
      CDBdata1   <= '0;
      CDBisCast2 <= 1'b0;
      CDBrobNum2 <= NO_ROB;
      CDBdata2   <= '0;
      dropCount  <= 8'd0;
      ptr        <= '0;
    end else begin
      grant      <= grant_d;
      CDBisCast1 <= cast1_d;
      CDBrobNum1 <= rob1_d;
      CDBdata1   <= data1_d;
      CDBisCast2 <= cast2_d;
      CDBrobNum2 <= rob2_d;
      CDBdata2   <= data2_d;
      dropCount  <= drop_d;
      ptr        <= ptr_d;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized
// requesters checked against a queue-based reference model.
module tb_cdb_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned TW    = 6;
  localparam int unsigned DW    = 32;
  localparam int unsigned OUT_W = N + 2 + 2*TW + 2*DW + 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          resetAll;
  logic [N-1:0]  req;
  logic [N*TW-1:0] reqRob;
  logic [N*DW-1:0] reqData;
  logic [N-1:0]  grant;
  logic          CDBisCast1;
  logic [TW-1:0] CDBrobNum1;
  logic [DW-1:0] CDBdata1;
  logic          CDBisCast2;
  logic [TW-1:0] CDBrobNum2;
  logic [DW-1:0] CDBdata2;
  logic [7:0]    dropCount;

  logic [TW-1:0] rob_v  [N];
  logic [DW-1:0] data_v [N];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [N-1:0]  m_grant;
  logic          m_cast1, m_cast2;
  logic [TW-1:0] m_rob1, m_rob2;
  logic [DW-1:0] m_data1, m_data2;
  int            m_drop;
  int            m_ptr;
  logic [N-1:0]  grant_prev;

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .resetAll(resetAll), .req(req),
    .reqRob(reqRob), .reqData(reqData), .grant(grant),
    .CDBisCast1(CDBisCast1), .CDBrobNum1(CDBrobNum1), .CDBdata1(CDBdata1),
    .CDBisCast2(CDBisCast2), .CDBrobNum2(CDBrobNum2), .CDBdata2(CDBdata2),
    .dropCount(dropCount)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      reqRob[i*TW +: TW]  = rob_v[i];
      reqData[i*DW +: DW] = data_v[i];
    end
  end

  // Model: eligible requesters in rotation order are paired with free buses in order.
  task automatic model_step();
    int order[$];
    int buses[$];
    if (rst) begin
      m_grant = '0; m_cast1 = 1'b0; m_cast2 = 1'b0;
      m_rob1 = TW'(16); m_rob2 = TW'(16); m_data1 = '0; m_data2 = '0;
      m_drop = 0; m_ptr = 0;
      return;
    end
    if (resetAll) begin
      m_grant = '0; m_cast1 = 1'b0; m_cast2 = 1'b0;
      return;
    end
    for (int k = 0; k < int'(N); k++) begin
      int i;
      i = (m_ptr + k) % int'(N);
      if (req[i] && !m_grant[i]) order.push_back(i);
    end
    if (!m_cast1) buses.push_back(1);
    if (!m_cast2) buses.push_back(2);
    m_grant = '0; m_cast1 = 1'b0; m_cast2 = 1'b0;
    for (int j = 0; j < order.size() && j < buses.size(); j++) begin
      int i;
      i = order[j];
      m_grant[i] = 1'b1;
      m_ptr = (i + 1) % int'(N);
      if (int'(rob_v[i]) >= 16) begin
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end else if (buses[j] == 1) begin
        m_cast1 = 1'b1; m_rob1 = rob_v[i]; m_data1 = data_v[i];
      end else begin
        m_cast2 = 1'b1; m_rob2 = rob_v[i]; m_data2 = data_v[i];
      end
    end
  endtask

  function automatic logic [OUT_W-1:0] dut_outs();
    return {grant, CDBisCast1, CDBrobNum1, CDBdata1, CDBisCast2, CDBrobNum2, CDBdata2, dropCount};
  endfunction

  function automatic logic [OUT_W-1:0] model_outs();
    return {m_grant, m_cast1, m_rob1, m_data1, m_cast2, m_rob2, m_data2, 8'(m_drop)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic new_result(input int i, input bit allow_drop);
    rob_v[i]  = allow_drop ? TW'($urandom_range(0, 19)) : TW'($urandom_range(0, 15));
    data_v[i] = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1; resetAll = 1'b0; req = '0;
    tick(); tick();
    rst = 1'b0;
    grant_prev = '0;
  endtask

  // Requesters: consumed ones may present a new result; waiting ones hold.
  task automatic requesters_step(input logic [N-1:0] consumed, input bit hold3);
    for (int i = 0; i < int'(N); i++) begin
      if (hold3 && i == 3) begin
        req[3] = 1'b1;
        if (consumed[3]) new_result(3, 1'b1);
      end else if (consumed[i] || !req[i]) begin
        req[i] = 1'($urandom_range(0, 1));
        if (req[i]) new_result(i, 1'b1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; resetAll = 1'b0; req = 4'b1111;
    for (int i = 0; i < int'(N); i++) new_result(i, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (grant !== 4'b0000 || CDBisCast1 !== 1'b0 || CDBisCast2 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_strobes cycle %0d: grant=%b cast1=%b cast2=%b, want 0000/0/0", c, grant, CDBisCast1, CDBisCast2);
      end
      n_checks++;
      if (CDBrobNum1 !== 6'd16 || CDBrobNum2 !== 6'd16 || CDBdata1 !== 32'd0 || CDBdata2 !== 32'd0 || dropCount !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_values cycle %0d: rob1=%0d rob2=%0d d1=%h d2=%h drop=%0d, want 16/16/0/0/0", c, CDBrobNum1, CDBrobNum2, CDBdata1, CDBdata2, dropCount);
      end
    end
    rst = 1'b0; req = '0;
    grant_prev = '0;
  endtask

  task automatic test_single();
    req = 4'b0100; rob_v[2] = 6'd5; data_v[2] = 32'hDEAD;
    tick();
    n_checks++;
    if (grant !== 4'b0100 || CDBisCast1 !== 1'b1 || CDBrobNum1 !== 6'd5 || CDBdata1 !== 32'hDEAD || CDBisCast2 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b c1=%b rob1=%0d d1=%h c2=%b, want 0100/1/5/0000dead/0", grant, CDBisCast1, CDBrobNum1, CDBdata1, CDBisCast2);
    end
    tick();
    n_checks++;
    if (grant !== 4'b0000 || CDBisCast1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: grant=%b cast1=%b, want 0000/0", grant, CDBisCast1);
    end
    req = '0;
    tick();
    n_checks++;
    if (dut_outs() !== model_outs()) begin
      n_fail++;
      $display("FAIL single_model: got %h want %h", dut_outs(), model_outs());
    end
  endtask

  task automatic test_all_four();
    logic [N-1:0] pat [4];
    logic prev1, prev2;
    pat = '{4'b0011, 4'b0000, 4'b1100, 4'b0000};
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < int'(N); i++) new_result(i, 1'b0);
    prev1 = 1'b0; prev2 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_checks++;
      if (grant !== pat[c % 4]) begin
        n_fail++;
        $display("FAIL all_four_grant cycle %0d: got %b want %b", c, grant, pat[c % 4]);
      end
      n_checks++;
      if ((prev1 && CDBisCast1) || (prev2 && CDBisCast2)) begin
        n_fail++;
        $display("FAIL all_four_gap cycle %0d: cast1 %b->%b cast2 %b->%b, want a low cycle between pulses", c, prev1, CDBisCast1, prev2, CDBisCast2);
      end
      n_checks++;
      if (dut_outs() !== model_outs()) begin
        n_fail++;
        $display("FAIL all_four_model cycle %0d: got %h want %h", c, dut_outs(), model_outs());
      end
      prev1 = CDBisCast1; prev2 = CDBisCast2;
      for (int i = 0; i < int'(N); i++) if (grant_prev[i]) new_result(i, 1'b0);
      grant_prev = m_grant;
    end
    req = '0;
  endtask

  task automatic test_drop();
    int exp_drop;
    do_reset();
    req = 4'b0010; rob_v[1] = 6'd16; data_v[1] = $urandom;
    tick();
    n_checks++;
    if (grant !== 4'b0010 || CDBisCast1 !== 1'b0 || CDBisCast2 !== 1'b0 || dropCount !== 8'd1) begin
      n_fail++;
      $display("FAIL drop_first: grant=%b c1=%b c2=%b drop=%0d, want 0010/0/0/1", grant, CDBisCast1, CDBisCast2, dropCount);
    end
    tick();
    req = 4'b0011; rob_v[0] = 6'd20; rob_v[1] = 6'd17;
    tick();
    n_checks++;
    if (grant !== 4'b0011 || CDBisCast1 !== 1'b0 || CDBisCast2 !== 1'b0 || dropCount !== 8'd3) begin
      n_fail++;
      $display("FAIL drop_double: grant=%b c1=%b c2=%b drop=%0d, want 0011/0/0/3", grant, CDBisCast1, CDBisCast2, dropCount);
    end
    tick();
    req = 4'b0010; rob_v[1] = TW'($urandom_range(16, 63));
    for (int c = 0; c < 600; c++) begin
      tick();
      exp_drop = 3 + c / 2 + 1;
      if (exp_drop > 255) exp_drop = 255;
      n_checks++;
      if (dropCount !== 8'(exp_drop) || CDBisCast1 !== 1'b0 || CDBisCast2 !== 1'b0) begin
        n_fail++;
        $display("FAIL drop_count cycle %0d: drop=%0d c1=%b c2=%b, want %0d/0/0", c, dropCount, CDBisCast1, CDBisCast2, exp_drop);
      end
      if (c % 2 == 1) rob_v[1] = TW'($urandom_range(16, 63));
    end
    n_checks++;
    if (dropCount !== 8'd255 || CDBrobNum1 !== 6'd16) begin
      n_fail++;
      $display("FAIL drop_saturate: drop=%0d rob1=%0d, want 255/16", dropCount, CDBrobNum1);
    end
    req = '0;
  endtask

  task automatic test_flush();
    do_reset();
    rob_v[0] = 6'd1; rob_v[3] = 6'd2; rob_v[1] = 6'd3; rob_v[2] = 6'd4;
    for (int i = 0; i < int'(N); i++) data_v[i] = $urandom;
    req = 4'b0110; resetAll = 1'b1;
    tick();
    n_checks++;
    if (grant !== 4'b0000 || CDBisCast1 !== 1'b0 || CDBisCast2 !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_block: grant=%b c1=%b c2=%b, want 0000/0/0", grant, CDBisCast1, CDBisCast2);
    end
    resetAll = 1'b0;
    tick();
    n_checks++;
    if (grant !== 4'b0110 || CDBrobNum1 !== 6'd3 || CDBrobNum2 !== 6'd4 || !CDBisCast1 || !CDBisCast2) begin
      n_fail++;
      $display("FAIL flush_resume: grant=%b rob1=%0d rob2=%0d, want 0110/3/4", grant, CDBrobNum1, CDBrobNum2);
    end
    tick();
    req = 4'b1001; resetAll = 1'b1;
    tick();
    resetAll = 1'b0;
    tick();
    n_checks++;
    if (grant !== 4'b1001 || CDBrobNum1 !== 6'd2 || CDBdata1 !== data_v[3] || CDBrobNum2 !== 6'd1) begin
      n_fail++;
      $display("FAIL flush_ptr_held: grant=%b rob1=%0d rob2=%0d, want 1001/2/1", grant, CDBrobNum1, CDBrobNum2);
    end
    n_checks++;
    if (dut_outs() !== model_outs()) begin
      n_fail++;
      $display("FAIL flush_model: got %h want %h", dut_outs(), model_outs());
    end
    tick();
    req = '0;
  endtask

  task automatic test_same_tag();
    do_reset();
    req = 4'b0011; rob_v[0] = 6'd9; rob_v[1] = 6'd9;
    data_v[0] = 32'h1111_AAAA; data_v[1] = 32'h2222_BBBB;
    tick();
    n_checks++;
    if (grant !== 4'b0011 || !CDBisCast1 || !CDBisCast2 || CDBrobNum1 !== 6'd9 || CDBrobNum2 !== 6'd9
        || CDBdata1 !== 32'h1111_AAAA || CDBdata2 !== 32'h2222_BBBB) begin
      n_fail++;
      $display("FAIL same_tag: grant=%b rob1=%0d rob2=%0d d1=%h d2=%h, want 0011/9/9/1111aaaa/2222bbbb", grant, CDBrobNum1, CDBrobNum2, CDBdata1, CDBdata2);
    end
    tick();
    req = '0;
  endtask

  task automatic test_starvation();
    int wait3;
    int sb_drop;
    do_reset();
    wait3 = 0; sb_drop = 0;
    req = 4'b1000;
    new_result(3, 1'b1);
    for (int c = 0; c < 1000; c++) begin
      logic [N-1:0]  s_req;
      logic [TW-1:0] s_rob  [N];
      logic [DW-1:0] s_data [N];
      bit            used   [N];
      int            want, got;
      bit            ok, hit;
      s_req = req;
      for (int i = 0; i < int'(N); i++) begin s_rob[i] = rob_v[i]; s_data[i] = data_v[i]; used[i] = 1'b0; end
      tick();
      n_checks++;
      if (dut_outs() !== model_outs()) begin
        n_fail++;
        $display("FAIL starve_model cycle %0d: got %h want %h", c, dut_outs(), model_outs());
      end
      // scoreboard: every grant is one broadcast or one drop
      ok = ((grant & ~s_req) == '0);
      want = 0;
      for (int i = 0; i < int'(N); i++) begin
        if (grant[i] && int'(s_rob[i]) < 16) want++;
        if (grant[i] && int'(s_rob[i]) >= 16 && sb_drop < 255) sb_drop++;
      end
      got = int'(CDBisCast1) + int'(CDBisCast2);
      if (want != got) ok = 1'b0;
      for (int b = 1; b <= 2; b++) begin
        logic cst; logic [TW-1:0] r; logic [DW-1:0] d;
        cst = (b == 1) ? CDBisCast1 : CDBisCast2;
        r   = (b == 1) ? CDBrobNum1 : CDBrobNum2;
        d   = (b == 1) ? CDBdata1   : CDBdata2;
        if (cst) begin
          hit = 1'b0;
          for (int i = 0; i < int'(N); i++) begin
            if (!hit && grant[i] && !used[i] && int'(s_rob[i]) < 16 && s_rob[i] == r && s_data[i] == d) begin
              used[i] = 1'b1; hit = 1'b1;
            end
          end
          if (!hit) ok = 1'b0;
        end
      end
      if (dropCount !== 8'(sb_drop)) ok = 1'b0;
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL starve_scoreboard cycle %0d: grant=%b casts=%0d want_casts=%0d drop=%0d want_drop=%0d", c, grant, got, want, dropCount, sb_drop);
      end
      if (grant[3]) wait3 = 0; else wait3++;
      n_checks++;
      if (wait3 > 5) begin
        n_fail++;
        $display("FAIL starve_wait3 cycle %0d: waited %0d cycles, want <= 5", c, wait3);
      end
      requesters_step(grant_prev, 1'b1);
      grant_prev = m_grant;
    end
    req = '0;
    tick();
  endtask

  task automatic test_random_flush();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] consumed;
      rst      = ($urandom_range(0, 63) == 0);
      resetAll = ($urandom_range(0, 9) == 0);
      tick();
      n_checks++;
      if (dut_outs() !== model_outs()) begin
        n_fail++;
        $display("FAIL random_model cycle %0d: got %h want %h", c, dut_outs(), model_outs());
      end
      consumed = (rst || resetAll) ? {N{1'b1}} : grant_prev;
      requesters_step(consumed, 1'b0);
      grant_prev = m_grant;
    end
    rst = 1'b0; resetAll = 1'b0; req = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; resetAll = 1'b0; req = '0;
    grant_prev = '0;
    for (int i = 0; i < int'(N); i++) begin rob_v[i] = '0; data_v[i] = '0; end
    test_reset();
    test_single();
    test_all_four();
    test_drop();
    test_flush();
    test_same_tag();
    test_starvation();
    test_random_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
